// File: rtl/branch_resolve_unit.sv
// Registered multi-lane branch resolver: decodes per-lane compare flags, checks them against
// the prediction, and flags the oldest mispredict with a kill mask and a one-cycle redirect shadow.
// Optional perf counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   stall,
  input  logic [NUM_LANES-1:0]   in_valid,
  input  logic [3*NUM_LANES-1:0] branch_type,
  input  logic [NUM_LANES-1:0]   eq,
  input  logic [NUM_LANES-1:0]   slt,
  input  logic [NUM_LANES-1:0]   ult,
  input  logic [NUM_LANES-1:0]   pred_taken,
  output logic [NUM_LANES-1:0]   out_valid,
  output logic [NUM_LANES-1:0]   taken,
  output logic                   mispredict,
  output logic [LANE_W-1:0]      mispredict_lane,
  output logic [NUM_LANES-1:0]   kill_mask,
  output logic                   shadow,
`ifdef BRU_PERF_CNT_EN
  output logic [CNT_W-1:0]       resolved_cnt,
  output logic [CNT_W-1:0]       mispred_cnt,
`endif
  output logic [0:0]             dbgState
);

  // Handshake: there is no backpressure; stall=1 freezes every register and the inputs
  // of that cycle are ignored. Outputs always describe the last accepted cycle.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;

  logic [0:0]           state;
  logic [NUM_LANES-1:0] dec;
  logic [NUM_LANES-1:0] effValid;
  logic [NUM_LANES-1:0] miss;
  logic [NUM_LANES-1:0] killNext;
  logic [NUM_LANES-1:0] validNext;
  logic [NUM_LANES-1:0] takenNext;
  logic [LANE_W-1:0]    winIdx;
  logic                 found;

  assign dbgState = state;

  always_comb begin
    dec      = '0;
    effValid = '0;
    miss     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (branch_type[3*i +: 3])
        3'b000:  dec[i] = eq[i];
        3'b001:  dec[i] = ~eq[i];
        3'b010:  dec[i] = slt[i];
        3'b011:  dec[i] = ~slt[i];
        3'b100:  dec[i] = ult[i];
        3'b101:  dec[i] = ~ult[i];
        default: dec[i] = 1'b0;
      endcase
      effValid[i] = in_valid[i] & (state == ST_RUN) & ~(mode & (i > 0));
      miss[i]     = effValid[i] & (dec[i] ^ pred_taken[i]);
    end
  end

  // Once the oldest miss is seen, every younger valid lane is squashed.
  always_comb begin
    winIdx   = '0;
    found    = 1'b0;
    killNext = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      killNext[i] = effValid[i] & found;
      if (miss[i] && !found) begin
        found  = 1'b1;
        winIdx = LANE_W'(i);
      end
    end
  end

  // taken is qualified by out_valid so dropped or killed lanes never report a direction.
  assign validNext = effValid & ~killNext;
  assign takenNext = dec & validNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RUN;
      out_valid       <= '0;
      taken           <= '0;
      mispredict      <= 1'b0;
      mispredict_lane <= '0;
      kill_mask       <= '0;
      shadow          <= 1'b0;
    end else if (!stall) begin
      out_valid       <= validNext;
      taken           <= takenNext;
      mispredict      <= found;
      mispredict_lane <= winIdx;
      kill_mask       <= killNext;
      shadow          <= (state == ST_SHADOW);
      state           <= (state == ST_RUN && found) ? ST_SHADOW : ST_RUN;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W:0] pop;
  logic [CNT_W:0] resSum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + {{CNT_W{1'b0}}, out_valid[i]};
    end
    resSum = {1'b0, resolved_cnt} + pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else if (!stall) begin
      resolved_cnt <= resSum[CNT_W] ? {CNT_W{1'b1}} : resSum[CNT_W-1:0];
      if (mispredict && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit (two lanes): directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model. Define BRU_PERF_CNT_EN to cover the counters.
module tb_branch_resolve_unit;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst, stall, mode;
  logic [1:0] in_valid, eq, slt, ult, pred_taken;
  logic [5:0] branch_type;
  logic [1:0] out_valid, taken, kill_mask;
  logic       mispredict, shadow;
  logic [0:0] mispredict_lane;
  logic [0:0] dbg_state;
`ifdef BRU_PERF_CNT_EN
  logic [CW-1:0] resolved_cnt, mispred_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.NUM_LANES(2), .LANE_W(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .stall(stall),
    .in_valid(in_valid), .branch_type(branch_type),
    .eq(eq), .slt(slt), .ult(ult), .pred_taken(pred_taken),
    .out_valid(out_valid), .taken(taken), .mispredict(mispredict),
    .mispredict_lane(mispredict_lane), .kill_mask(kill_mask), .shadow(shadow),
`ifdef BRU_PERF_CNT_EN
    .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt),
`endif
    .dbgState(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       bubble;   // next accepted cycle is the redirect bubble
    logic       sh;
    logic [1:0] km;
    logic [0:0] lane;
    logic       mp;
    logic [1:0] tk;
    logic [1:0] ov;
`ifdef BRU_PERF_CNT_EN
    logic [CW-1:0] rc;
    logic [CW-1:0] mc;
`endif
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t m = '0;

  function automatic bit resolve(input logic [2:0] t, input logic e, input logic s, input logic u);
    bit base;
    case (t[2:1])
      2'd0:    base = e;
      2'd1:    base = s;
      2'd2:    base = u;
      default: return 1'b0;
    endcase
    return base ^ t[0];
  endfunction

  always @(posedge clk) begin : model
    int  first;
    bit  v, d;
    if (rst) begin
      m = '0;
    end else if (!stall) begin
`ifdef BRU_PERF_CNT_EN
      m.rc = ((int'(m.rc) + $countones(m.ov)) > 15) ? CW'(15) : CW'(int'(m.rc) + $countones(m.ov));
      m.mc = (m.mp && m.mc != CW'(15)) ? m.mc + 1'b1 : m.mc;
`endif
      if (m.bubble) begin
        m.ov = '0; m.tk = '0; m.mp = 1'b0; m.lane = '0; m.km = '0;
        m.sh = 1'b1; m.bubble = 1'b0;
      end else begin
        first = -1;
        m.ov = '0; m.tk = '0; m.km = '0;
        for (int i = 0; i < 2; i++) begin
          v = in_valid[i] && (i == 0 || !mode);
          d = resolve(branch_type[3*i +: 3], eq[i], slt[i], ult[i]);
          if (v && first >= 0) begin
            m.km[i] = 1'b1;
          end else if (v) begin
            m.ov[i] = 1'b1;
            m.tk[i] = d;
            if (d != pred_taken[i]) first = i;
          end
        end
        m.mp     = (first >= 0);
        m.lane   = (first > 0) ? 1'b1 : 1'b0;
        m.sh     = 1'b0;
        m.bubble = m.mp;
      end
    end
    exp_q.push_back(EXP_W'(m));
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("m_out_valid", 32'(out_valid), 32'(e.ov));
      chk("m_taken", 32'(taken), 32'(e.tk));
      chk("m_mispredict", 32'(mispredict), 32'(e.mp));
      chk("m_lane", 32'(mispredict_lane), 32'(e.lane));
      chk("m_kill_mask", 32'(kill_mask), 32'(e.km));
      chk("m_shadow", 32'(shadow), 32'(e.sh));
      chk("m_state", 32'(dbg_state), 32'(e.bubble));
`ifdef BRU_PERF_CNT_EN
      chk("m_resolved_cnt", 32'(resolved_cnt), 32'(e.rc));
      chk("m_mispred_cnt", 32'(mispred_cnt), 32'(e.mc));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic st, input logic md, input logic [1:0] v,
                      input logic [5:0] bt, input logic [1:0] e, input logic [1:0] s,
                      input logic [1:0] u, input logic [1:0] p);
    rst = r; stall = st; mode = md; in_valid = v; branch_type = bt;
    eq = e; slt = s; ult = u; pred_taken = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic chk_out(input string name, input logic [1:0] ov, input logic [1:0] tk,
                         input logic mp, input logic ln, input logic [1:0] km, input logic sh);
    chk({name, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({name, "_taken"}, 32'(taken), 32'(tk));
    chk({name, "_mispredict"}, 32'(mispredict), 32'(mp));
    chk({name, "_lane"}, 32'(mispredict_lane), 32'(ln));
    chk({name, "_kill_mask"}, 32'(kill_mask), 32'(km));
    chk({name, "_shadow"}, 32'(shadow), 32'(sh));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(1'b1, 1'b0, 1'b0, 2'b00, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b11, 6'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    chk_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    // lane0 BEQ eq=1 pred=1; lane1 BLTU ult=0 pred=0
    step(1'b0, 1'b0, 1'b0, 2'b11, 6'b100_000, 2'b01, 2'b00, 2'b00, 2'b01);
    chk_out("t1", 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);

    // lane0 BNE eq=1 pred=1 mispredicts; lane1 killed; next cycle is the bubble
    step(1'b0, 1'b0, 1'b0, 2'b11, 6'b000_001, 2'b01, 2'b00, 2'b00, 2'b01);
    chk_out("t2", 2'b01, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b11, 6'b000_000, 2'b11, 2'b00, 2'b00, 2'b11);
    chk_out("t2_shadow", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);

    // unified mode: lane1 would mispredict but is ignored
    step(1'b0, 1'b0, 1'b1, 2'b11, 6'b000_000, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_out("t3", 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    // split mode: only lane1 mispredicts
    step(1'b0, 1'b0, 1'b0, 2'b11, 6'b000_000, 2'b01, 2'b00, 2'b00, 2'b11);
    chk_out("lane1_miss", 2'b11, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0);
    idle();

    // reserved type resolves not-taken whatever the flags
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_110, 2'b11, 2'b11, 2'b11, 2'b00);
    chk_out("type110", 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    // decode sweep on lane0 with both flag polarities
    for (int t = 0; t < 8; t++) begin
      for (int f = 0; f < 2; f++) begin
        step(1'b0, 1'b0, 1'b0, 2'b01, {3'b000, 3'(t)}, {1'b0, 1'(f)}, {1'b0, 1'(f)},
             {1'b0, 1'(f)}, 2'b00);
        idle();
      end
    end

    // mispredict, then a 3-cycle stall: outputs frozen, bubble on first free cycle
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_001, 2'b01, 2'b00, 2'b00, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11, 6'b000_000, 2'b00, 2'b00, 2'b00, 2'b11);
      chk_out("t4_stall", 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_000, 2'b01, 2'b00, 2'b00, 2'b01);
    chk_out("t4_shadow", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_000, 2'b01, 2'b00, 2'b00, 2'b01);
    chk_out("t4_after", 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);

    // reset (with stall) while the bubble is pending wins
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_001, 2'b01, 2'b00, 2'b00, 2'b01);
    step(1'b1, 1'b1, 1'b0, 2'b11, 6'b000_000, 2'b11, 2'b00, 2'b00, 2'b11);
    chk_out("t5_rst", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("t5_state", 32'(dbg_state), 32'd0);
    step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_000, 2'b01, 2'b00, 2'b00, 2'b01);
    chk_out("t5_resume", 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)));
    end

`ifdef BRU_PERF_CNT_EN
    // 20 separated single-lane mispredicts saturate both 4-bit counters
    step(1'b1, 1'b0, 1'b0, 2'b00, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("cnt_rst_res", 32'(resolved_cnt), 32'd0);
    chk("cnt_rst_mis", 32'(mispred_cnt), 32'd0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b01, 6'b000_001, 2'b01, 2'b00, 2'b00, 2'b01);
      idle();
    end
    chk("cnt_resolved_sat", 32'(resolved_cnt), 32'd15);
    chk("cnt_mispred_sat", 32'(mispred_cnt), 32'd15);
`endif

    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
